syscall_console: RTL and testbench
==================================

SYSCALL_CONSOLE -- requirements
Module: syscall_console

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16; output character FIFO depth, a power of two, 2 to 256.
REQ-002 SHALL have parameter DIGIT_PER_CYCLE, default 1; number of print_int digits produced per cycle, 1 or 2.
REQ-003 SHALL have port clock, input, 1, sole clock, all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, syscall request present from the execute stage.
REQ-006 SHALL have port req_ready, output, 1, block accepts a request this cycle.
REQ-007 SHALL have port req_funct, input, 32, syscall function code ($v0).
REQ-008 SHALL have port req_param1, input, 32, first argument ($a0).
REQ-009 SHALL have port out_valid, output, 1, out_char holds a console byte.
REQ-010 SHALL have port out_ready, input, 1, console sink takes the byte.
REQ-011 SHALL have port out_char, output, 8, console byte (FIFO head).
REQ-012 SHALL have port stall, output, 1, pipeline must hold execute stage (req_valid high and req_ready low).
REQ-013 SHALL have port halted, output, 1, exit completed; sticky until reset.

Function
REQ-014 Request SHALL be accepted when req_valid and req_ready are both high on a rising edge; funct and param1 SHALL be captured then.
REQ-015 req_ready SHALL be high only in state IDLE with halted low.
REQ-016 States SHALL be IDLE, PUTC, INT_SIGN, INT_DIGIT, EXIT_DRAIN, HALT.
REQ-017 IDLE transitions on accept: PUT_C code -> PUTC; PRINT_INT code -> INT_SIGN; EXIT code -> EXIT_DRAIN; any other code -> IDLE (ignored, no output).
REQ-018 PUTC SHALL push req_param1[7:0] once FIFO not full, then -> IDLE.
REQ-019 INT_SIGN SHALL treat param1 as signed two's complement; if negative push '-' (0x2D) and form 32-bit unsigned magnitude (0x80000000 -> 2147483648 exactly); then -> INT_DIGIT.
REQ-020 INT_DIGIT SHALL emit decimal digits most-significant first by comparison against powers of ten 10^9..10^0, DIGIT_PER_CYCLE digits per cycle, leading zeros suppressed, value 0 emitting single '0'; no newline; last digit pushed -> IDLE.
REQ-021 Any push SHALL wait (state and digit index held) while FIFO full; no byte SHALL be dropped or duplicated.
REQ-022 FIFO pop SHALL occur when out_valid and out_ready are high; out_valid = FIFO not empty; simultaneous push and pop SHALL keep count unchanged, allowed when full only if pop occurs that cycle.
REQ-023 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-024 EXIT_DRAIN SHALL wait until FIFO empty, then -> HALT; HALT SHALL set halted, hold req_ready low forever.
REQ-025 Latency: accepted PUT_C byte SHALL appear on out_char the cycle after push (registered FIFO, no bypass).
REQ-026 out_char SHALL be 0x00 when out_valid low.

Reset
REQ-027 reset SHALL force state IDLE, FIFO empty, pointers 0, out_valid 0, out_char 0x00, halted 0, req_ready 1 next cycle.
REQ-028 reset SHALL take priority over any request or pop in the same cycle; a partially printed integer SHALL be abandoned.

Structure
REQ-029 Syscall codes SHALL live in the shared syscall header: PRINT_INT 1, EXIT 10, PUT_C 11; powers-of-ten table in same header.
REQ-030 FIFO SHALL be one sub-module, syscall_char_fifo, parametrised by depth and width 8.
REQ-031 Implementation SHALL be synthesizable: no $display or $finish; simulation console driven from out_char by the testbench.

Verification
REQ-032 PUT_C param1 0x00000141, out_ready 1 -> single byte 0x41, then req_ready high.
REQ-033 PRINT_INT 0xFFFFFF85 (-123) -> bytes 0x2D,0x31,0x32,0x33 in order.
REQ-034 PRINT_INT 0x80000000 -> "-2147483648" (11 bytes); PRINT_INT 0 -> single 0x30.
REQ-035 FIFO_DEPTH 4, out_ready 0, PRINT_INT 1234567890 -> stall high after 4 pushes, count 4; out_ready 1 -> all 10 digits exact, no loss.
REQ-036 PUT_C 'A' then EXIT with out_ready 0 for 5 cycles -> halted low until 'A' popped, then halted 1 and req_ready 0.
REQ-037 reset asserted mid PRINT_INT 1000000 -> next cycle out_valid 0, state IDLE; new PUT_C 'Z' outputs only 0x5A.

Source files
------------

// File: rtl/syscall_console_pkg.sv
// ----------------------------------------------------------------------------
// syscall_console_pkg
//   Shared syscall header for the console block: syscall function codes,
//   FSM state encodings, the powers-of-ten table used for decimal printing
//   and a helper that extracts one decimal digit by repeated comparison.
// ----------------------------------------------------------------------------
package syscall_console_pkg;

    // Syscall function codes ($v0)
    localparam logic [31:0] SYS_PRINT_INT = 32'd1;
    localparam logic [31:0] SYS_EXIT      = 32'd10;
    localparam logic [31:0] SYS_PUT_C     = 32'd11;

    // Controller states
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_PUTC       = 3'd1;
    localparam logic [2:0] ST_INT_SIGN   = 3'd2;
    localparam logic [2:0] ST_INT_DIGIT  = 3'd3;
    localparam logic [2:0] ST_EXIT_DRAIN = 3'd4;
    localparam logic [2:0] ST_HALT       = 3'd5;

    // Digit index 0 addresses 10^9, index 9 addresses 10^0 (units)
    localparam logic [3:0] LAST_DIGIT = 4'd9;

    localparam logic [7:0] CHAR_MINUS = 8'h2D;
    localparam logic [7:0] CHAR_ZERO  = 8'h30;

    typedef struct packed {
        logic [3:0]  digit;
        logic [31:0] rem;
    } digit_split_t;

    // Powers-of-ten table, most significant first
    function automatic logic [31:0] pow10(input logic [3:0] idx);
        logic [31:0] p;
        case (idx)
            4'd0:    p = 32'd1000000000;
            4'd1:    p = 32'd100000000;
            4'd2:    p = 32'd10000000;
            4'd3:    p = 32'd1000000;
            4'd4:    p = 32'd100000;
            4'd5:    p = 32'd10000;
            4'd6:    p = 32'd1000;
            4'd7:    p = 32'd100;
            4'd8:    p = 32'd10;
            default: p = 32'd1;
        endcase
        return p;
    endfunction

    // Digit at position idx of val and the remainder once that digit's weight
    // is removed. Multiples of the power are built by accumulation and kept
    // 36 bits wide because 9 * 10^9 does not fit in 32 bits.
    function automatic digit_split_t split_digit(input logic [31:0] val,
                                                 input logic [3:0]  idx);
        logic [35:0]  step;
        logic [35:0]  acc;
        logic [35:0]  val_w;
        digit_split_t r;
        step    = {4'd0, pow10(idx)};
        acc     = '0;
        val_w   = {4'd0, val};
        r.digit = 4'd0;
        r.rem   = val;
        for (int k = 1; k <= 9; k++) begin
            acc = acc + step;
            // acc <= val here, so its low 32 bits are exact
            if (val_w >= acc) begin
                r.digit = 4'(k);
                r.rem   = val - acc[31:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/syscall_char_fifo.sv
// ----------------------------------------------------------------------------
// syscall_char_fifo
//   Registered character FIFO. A pushed byte becomes visible on rd_data the
//   cycle after the push (no write-to-read bypass). rd_data reads 0 when
//   empty. A push while full is taken only if a pop happens the same cycle.
// Ports
//   clock, reset   : clock, synchronous active-high reset
//   push/push_data : write request and byte
//   push_ok        : the write request will be taken this cycle
//   pop            : read request (ignored when empty)
//   rd_data        : head byte, 0 when empty
//   empty          : FIFO holds no bytes
// ----------------------------------------------------------------------------
module syscall_char_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ok,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign push_ok = !full || do_pop;
    assign do_push = push && push_ok;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: rd_data is masked while empty
    always_ff @(posedge clock) begin
        if (!reset && do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/syscall_console.sv
// ----------------------------------------------------------------------------
// syscall_console
//   Executes console syscalls from the execute stage: PUT_C pushes one byte,
//   PRINT_INT pushes the signed decimal text of $a0, EXIT waits for the
//   console to drain and then halts. Bytes leave through a ready/valid port
//   backed by syscall_char_fifo.
// Ports
//   clock, reset            : clock, synchronous active-high reset
//   req_valid/req_ready     : request handshake
//   req_funct, req_param1   : syscall code ($v0) and argument ($a0)
//   out_valid/out_ready     : console byte handshake
//   out_char                : FIFO head, 0 when out_valid is low
//   stall                   : request waiting but not accepted
//   halted                  : EXIT completed, sticky until reset
// ----------------------------------------------------------------------------
module syscall_console
    import syscall_console_pkg::*;
#(
    parameter int FIFO_DEPTH      = 16,
    parameter int DIGIT_PER_CYCLE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_funct,
    input  logic [31:0] req_param1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_char,
    output logic        stall,
    output logic        halted
);

    logic [2:0]  state_q,   state_d;
    logic [31:0] param_q,   param_d;
    logic [31:0] mag_q,     mag_d;
    logic [3:0]  idx_q,     idx_d;
    logic        started_q, started_d;
    logic        halted_q,  halted_d;

    logic        push_req;
    logic [7:0]  push_byte;
    logic        push_ok;
    logic        fifo_empty;

    assign req_ready = (state_q == ST_IDLE) && !halted_q;
    assign stall     = req_valid && !req_ready;
    assign halted    = halted_q;
    assign out_valid = !fifo_empty;

    syscall_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_req),
        .push_data (push_byte),
        .push_ok   (push_ok),
        .pop       (out_ready),
        .rd_data   (out_char),
        .empty     (fifo_empty)
    );

    always_comb begin
        logic [31:0]  walk_mag;
        logic [3:0]   walk_idx;
        logic         walk_started;
        logic         walk_emit;
        logic         walk_last;
        digit_split_t walk_split;

        state_d      = state_q;
        param_d      = param_q;
        mag_d        = mag_q;
        idx_d        = idx_q;
        started_d    = started_q;
        halted_d     = halted_q;
        push_req     = 1'b0;
        push_byte    = 8'h00;
        walk_mag     = mag_q;
        walk_idx     = idx_q;
        walk_started = started_q;
        walk_emit    = 1'b0;
        walk_last    = 1'b0;
        walk_split   = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    param_d   = req_param1;
                    idx_d     = '0;
                    started_d = 1'b0;
                    if (req_funct == SYS_PUT_C)          state_d = ST_PUTC;
                    else if (req_funct == SYS_PRINT_INT) state_d = ST_INT_SIGN;
                    else if (req_funct == SYS_EXIT)      state_d = ST_EXIT_DRAIN;
                end
            end

            ST_PUTC: begin
                push_req  = 1'b1;
                push_byte = param_q[7:0];
                if (push_ok) state_d = ST_IDLE;
            end

            ST_INT_SIGN: begin
                if (param_q[31]) begin
                    push_req  = 1'b1;
                    push_byte = CHAR_MINUS;
                    if (push_ok) begin
                        // 0x80000000 negates to itself = 2147483648 unsigned
                        mag_d   = ~param_q + 32'd1;
                        state_d = ST_INT_DIGIT;
                    end
                end else begin
                    mag_d   = param_q;
                    state_d = ST_INT_DIGIT;
                end
            end

            ST_INT_DIGIT: begin
                // Walk up to DIGIT_PER_CYCLE positions. Suppressed leading
                // zeros cost no push; the walk stops at the first byte since
                // the FIFO takes one byte per cycle. Units always print.
                for (int j = 0; j < DIGIT_PER_CYCLE; j++) begin
                    if (!walk_emit) begin
                        walk_split = split_digit(walk_mag, walk_idx);
                        if (walk_split.digit == 4'd0 && !walk_started &&
                            walk_idx != LAST_DIGIT) begin
                            walk_idx = walk_idx + 4'd1;
                        end else begin
                            walk_emit    = 1'b1;
                            push_req     = 1'b1;
                            push_byte    = CHAR_ZERO | {4'h0, walk_split.digit};
                            walk_mag     = walk_split.rem;
                            walk_started = 1'b1;
                            walk_last    = (walk_idx == LAST_DIGIT);
                            if (!walk_last) walk_idx = walk_idx + 4'd1;
                        end
                    end
                end
                // A blocked push holds the whole walk, skipped zeros included
                if (!walk_emit || push_ok) begin
                    mag_d     = walk_mag;
                    idx_d     = walk_idx;
                    started_d = walk_started;
                    if (walk_last) state_d = ST_IDLE;
                end
            end

            ST_EXIT_DRAIN: begin
                if (fifo_empty) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end
            end

            ST_HALT: halted_d = 1'b1;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            param_q   <= '0;
            mag_q     <= '0;
            idx_q     <= '0;
            started_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            param_q   <= param_d;
            mag_q     <= mag_d;
            idx_q     <= idx_d;
            started_q <= started_d;
            halted_q  <= halted_d;
        end
    end

endmodule

// File: tb/tb_syscall_console.sv
module tb_syscall_console;

    localparam logic [31:0] F_PRINT_INT = 32'd1;
    localparam logic [31:0] F_EXIT      = 32'd10;
    localparam logic [31:0] F_PUT_C     = 32'd11;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_funct = '0;
    logic [31:0] req_param1 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_char;
    logic        stall;
    logic        halted;

    int errors = 0;
    int checks = 0;
    int ready_mode = 0;   // 0 hold low, 1 hold high, 2 random
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    syscall_console #(.FIFO_DEPTH(4), .DIGIT_PER_CYCLE(1)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct  (req_funct),
        .req_param1 (req_param1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_char   (out_char),
        .stall      (stall),
        .halted     (halted)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (ready_mode == 2) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Console sink: record every byte that will be taken at the next edge
    always begin
        @(negedge clock);
        #1;
        if (!reset) begin
            if (out_valid && out_ready) got_q.push_back(out_char);
            checks++;
            if (stall !== (req_valid && !req_ready)) begin
                errors++;
                $display("FAIL stall_rule: stall=%b req_valid=%b req_ready=%b", stall, req_valid, req_ready);
            end
            if (!out_valid) begin
                checks++;
                if (out_char !== 8'h00) begin
                    errors++;
                    $display("FAIL idle_char: got %h want 00", out_char);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic set_ready(input int m);
        ready_mode = m;
        if (m < 2) out_ready = (m == 1);
    endtask

    // Reference model: the console text the syscall should produce
    task automatic expect_req(input logic [31:0] f, input logic [31:0] p);
        string s;
        if (f == F_PUT_C) exp_q.push_back(p[7:0]);
        else if (f == F_PRINT_INT) begin
            s = $sformatf("%0d", $signed(p));
            for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        end
    endtask

    task automatic send(input logic [31:0] f, input logic [31:0] p, input string name);
        int n;
        n = 0;
        @(negedge clock);
        req_valid = 1'b1; req_funct = f; req_param1 = p;
        while (!req_ready && n < 500) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL %s_accept: req_ready never rose within %0d cycles", name, n);
        end
        @(negedge clock);
        req_valid = 1'b0; req_funct = '0; req_param1 = '0;
        expect_req(f, p);
    endtask

    task automatic check_stream(input string name);
        int n;
        int lim;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 3000) begin
            @(negedge clock);
            n++;
        end
        repeat (8) @(negedge clock);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s_len: got %0d bytes want %0d", name, got_q.size(), exp_q.size());
        end
        lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < lim; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_byte%0d: got %h want %h", name, i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (out_char !== 8'h00) begin errors++; $display("FAIL reset_out_char: got %h want 00", out_char); end
        if (halted !== 1'b0)    begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_putc();
        set_ready(1);
        send(F_PUT_C, 32'h0000_0141, "putc");
        // accept edge, push edge, then the byte is on out_char
        @(negedge clock);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL putc_latency_valid: got %b want 1", out_valid); end
        if (out_char !== 8'h41) begin errors++; $display("FAIL putc_latency_char: got %h want 41", out_char); end
        check_stream("putc");
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL putc_ready_after: got %b want 1", req_ready); end
    endtask

    task automatic test_print_int();
        set_ready(1);
        send(F_PRINT_INT, 32'hFFFF_FF85, "neg123");
        check_stream("neg123");
        send(F_PRINT_INT, 32'h8000_0000, "intmin");
        check_stream("intmin");
        send(F_PRINT_INT, 32'h0000_0000, "zero");
        check_stream("zero");
        send(F_PRINT_INT, 32'h7FFF_FFFF, "intmax");
        send(F_PRINT_INT, 32'd1000000000, "pow9");
        send(32'd7, 32'h0000_0042, "unknown");
        send(F_PRINT_INT, 32'd9, "nine");
        check_stream("mixed");
    endtask

    task automatic test_backpressure();
        int n;
        set_ready(0);
        send(F_PRINT_INT, 32'd1234567890, "bp");
        @(negedge clock);
        req_valid = 1'b1; req_funct = F_PUT_C; req_param1 = 32'h78;
        repeat (15) @(negedge clock);
        checks += 4;
        if (stall !== 1'b1) begin errors++; $display("FAIL bp_stall: got %b want 1", stall); end
        if (dut.u_fifo.count_q !== 3'd4) begin errors++; $display("FAIL bp_count: got %0d want 4", dut.u_fifo.count_q); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", out_valid); end
        if (out_char !== 8'h31) begin errors++; $display("FAIL bp_head: got %h want 31", out_char); end
        set_ready(1);
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (!req_ready) begin errors++; $display("FAIL bp_accept: req_ready never rose"); end
        @(negedge clock);
        req_valid = 1'b0; req_funct = '0; req_param1 = '0;
        expect_req(F_PUT_C, 32'h78);
        check_stream("bp");
    endtask

    task automatic test_random();
        logic [31:0] f;
        logic [31:0] p;
        int k;
        set_ready(2);
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 9);
            p = $urandom;
            if (k < 4) f = F_PUT_C;
            else if (k < 8) begin
                f = F_PRINT_INT;
                case ($urandom_range(0, 5))
                    0: p = 32'h8000_0000;
                    1: p = 32'h7FFF_FFFF;
                    2: p = 32'hFFFF_FFFF;
                    3: p = $urandom_range(0, 99);
                    default: ;
                endcase
            end else begin
                f = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(2, 9)) : $urandom;
                if (f == F_PUT_C || f == F_PRINT_INT || f == F_EXIT) f = 32'd2;
            end
            send(f, p, "rand");
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        check_stream("rand");
    endtask

    task automatic test_exit();
        int n;
        set_ready(0);
        send(F_PUT_C, 32'h41, "exit_putc");
        send(F_EXIT, 32'h0, "exit");
        repeat (5) begin
            @(negedge clock);
            checks++;
            if (halted !== 1'b0) begin errors++; $display("FAIL exit_early_halt: got %b want 0", halted); end
        end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL exit_pending: got %b want 1", out_valid); end
        set_ready(1);
        n = 0;
        while (!halted && n < 50) begin
            @(negedge clock);
            n++;
        end
        checks += 3;
        if (halted !== 1'b1)    begin errors++; $display("FAIL exit_halted: got %b want 1", halted); end
        if (got_q.size() != 1)  begin errors++; $display("FAIL exit_order: popped %0d bytes at halt want 1", got_q.size()); end
        if (req_ready !== 1'b0) begin errors++; $display("FAIL exit_ready: got %b want 0", req_ready); end
        req_valid = 1'b1; req_funct = F_PUT_C; req_param1 = 32'h42;
        repeat (3) @(negedge clock);
        checks += 2;
        if (stall !== 1'b1)  begin errors++; $display("FAIL exit_stall: got %b want 1", stall); end
        if (halted !== 1'b1) begin errors++; $display("FAIL exit_sticky: got %b want 1", halted); end
        req_valid = 1'b0; req_funct = '0; req_param1 = '0;
        check_stream("exit");
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        set_ready(0);
        send(F_PRINT_INT, 32'd1000000, "mid");
        repeat (10) @(negedge clock);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_partial: got %b want 1", out_valid); end
        reset = 1'b1;
        @(negedge clock);
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", out_valid); end
        if (out_char !== 8'h00) begin errors++; $display("FAIL mid_char: got %h want 00", out_char); end
        if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_idle: got %b want 1", req_ready); end
        reset = 1'b0;
        exp_q.delete();
        got_q.delete();
        set_ready(1);
        send(F_PUT_C, 32'h5A, "mid_z");
        repeat (10) @(negedge clock);
        check_stream("mid_z");
    endtask

    initial begin
        test_reset();
        test_putc();
        test_print_int();
        test_backpressure();
        test_random();
        test_exit();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
